// File: rtl/uart_xmit_frame.sv
// uart_xmit_frame: self-timed UART transmit framer (start, LSB-first data, optional parity, stop bits)
module uart_xmit_frame #(
    parameter int DATA_W    = 8,
    parameter int BAUD_DIV  = 5208,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              txd,
    output logic              busy
);
    localparam int N  = 1 + DATA_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    logic [0:0]    state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  frame;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic          baud_tc;
    logic          last;
    logic          accept;
    assign baud_tc = baud_cnt == BW'(BAUD_DIV - 1);
    assign last    = bit_cnt == CW'(N - 1);
    assign busy    = state == SEND;
    assign ready   = !busy || (baud_tc && last);
    assign accept  = valid && ready;
    // The shift register idles all ones, so bit 0 doubles as the registered line.
    assign txd     = shreg[0];
    always_comb begin
        frame = '1;
        frame[DATA_W:0] = {data, 1'b0};
        if (PARITY != 0) frame[DATA_W+1] = (PARITY == 2) ? ~^data : ^data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            state    <= SEND;
            shreg    <= frame;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (busy) begin
            if (baud_tc) begin
                baud_cnt <= '0;
                shreg    <= {1'b1, shreg[N-1:1]};
                bit_cnt  <= last ? '0 : bit_cnt + 1'b1;
                if (last) state <= IDLE;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end
endmodule
